serializer_tx: RTL and testbench
================================

SERIALIZER_TX -- requirements
Module: serializer_tx

Interface
REQ-001 Parameter DATA_W, default 8, frame payload width in bits.
REQ-002 Parameter FIFO_DEPTH, default 2, input buffer entries, power of two, at least 2.
REQ-003 Parameter GAP_CYCLES, default 0, idle cycles inserted after each frame, range 0..15.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_data  input  DATA_W  parallel word to transmit.
REQ-007 in_valid  input  1  in_data is valid this cycle.
REQ-008 in_ready  output  1  block accepts in_data this cycle.
REQ-009 load_out  output  1  frame-start strobe for the downstream deserializer.
REQ-010 serial_out  output  1  serial data bit, LSB first.
REQ-011 busy  output  1  a frame or gap is in progress.
REQ-012 frame_done  output  1  one-cycle pulse in the cycle carrying the last bit of a frame.

Function
REQ-013 A word SHALL be accepted only on a rising edge where in_valid and in_ready are both 1.
REQ-014 in_ready SHALL equal not-FIFO-full, so it depends only on registered state.
REQ-015 Accepted words SHALL be transmitted in acceptance order, none dropped, none duplicated.
REQ-016 FSM states SHALL be IDLE, LOAD, SHIFT and GAP.
REQ-017 IDLE: if the FIFO is non-empty, pop the head into the shift register and go to LOAD on the next edge; otherwise stay in IDLE.
REQ-018 LOAD: load_out SHALL be 1 and serial_out 0 for exactly one cycle, then go to SHIFT with bit index 0.
REQ-019 SHIFT: serial_out SHALL equal shift-register bit i in the i-th SHIFT cycle, for i = 0..DATA_W-1; load_out SHALL be 0.
REQ-020 frame_done SHALL be 1 in the SHIFT cycle where i = DATA_W-1.
REQ-021 From the last SHIFT cycle the FSM SHALL go to GAP when GAP_CYCLES > 0, otherwise directly back to IDLE/LOAD.
REQ-022 GAP SHALL last exactly GAP_CYCLES cycles, with load_out and serial_out both 0.
REQ-023 With GAP_CYCLES = 0 and the FIFO non-empty at the last SHIFT cycle, the next LOAD SHALL occur in the following cycle, giving DATA_W+1 cycles per frame with no idle cycle.
REQ-024 Latency: a word accepted into an empty, idle block at edge T SHALL produce load_out in cycle T+1 and bit 0 in cycle T+2.
REQ-025 A simultaneous push and pop SHALL be legal when the FIFO is full; the occupancy stays unchanged and in_ready stays 0 in that cycle.
REQ-026 Pointer wrap-around SHALL be modulo FIFO_DEPTH, with a separate count or an extra pointer bit to tell full from empty.
REQ-027 busy SHALL be 1 in LOAD, SHIFT and GAP, and 0 in IDLE.
REQ-028 in_data SHALL be ignored when in_valid = 0; words presented while in_ready = 0 are not accepted and the source must hold them.

Reset
REQ-029 While reset = 1: FSM in IDLE, FIFO empty, bit index 0, shift register 0.
REQ-030 While reset = 1 the outputs SHALL be load_out = 0, serial_out = 0, busy = 0, frame_done = 0 and in_ready = 1.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately and discard all buffered words; no partial frame resumes after release.

Structure
REQ-032 Shared package ser_pkg SHALL hold the FSM state enum (IDLE, LOAD, SHIFT, GAP) and the default DATA_W constant; the downstream deserializer uses the same DATA_W.
REQ-033 The FIFO SHALL be a separate sub-module, ser_fifo, with push, pop, full, empty and data signals, async reset, and no bypass path.

Verification
REQ-034 Send single word 0xA5 at T -> load_out = 1 at T+1; serial_out = 1,0,1,0,0,1,0,1 at T+2..T+9; frame_done = 1 at T+9; busy = 0 at T+10.
REQ-035 Back-to-back 0x3C then 0xC3, GAP_CYCLES = 0 -> load_out pulses exactly 9 cycles apart; bits are 0,0,1,1,1,1,0,0 then 1,1,0,0,0,0,1,1.
REQ-036 Hold in_valid = 1 for 4 words from idle with FIFO_DEPTH = 2 -> in_ready drops after the FIFO fills; all 4 words are transmitted in order and none is lost.
REQ-037 GAP_CYCLES = 3 with two queued words -> exactly 3 cycles with load_out = 0, serial_out = 0, busy = 1 between frame_done and the next load_out.
REQ-038 Assert reset during the 4th SHIFT cycle with 1 word queued -> outputs are 0 immediately; after release no load_out occurs until a new word is accepted.
REQ-039 Loopback to the downstream deserializer with 256 random words -> a bench monitor sampling serial_out on the 8 cycles after each load_out reconstructs every word exactly.

Source files
------------

// File: rtl/ser_pkg.sv
// Shared definitions for the serializer transmit path and its downstream deserializer.
package ser_pkg;

  localparam int SER_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } ser_state_t;

endpackage

// File: rtl/serializer_tx_if.sv
// Parallel word handshake into serializer_tx: source drives data/valid, block returns ready.
interface serializer_tx_if import ser_pkg::*; #(
  parameter int DATA_W = SER_DATA_W
) ();

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/ser_fifo.sv
// Small power-of-two FIFO with occupancy count; head word is read combinationally from storage.
module ser_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              do_push;
  logic              do_pop;

  // A push into a full FIFO is only safe when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/serializer_tx.sv
// Parallel-to-serial transmitter: buffered words go out LSB first, each framed by a load strobe.
module serializer_tx import ser_pkg::*; #(
  parameter int DATA_W     = SER_DATA_W,
  parameter int FIFO_DEPTH = 2,
  parameter int GAP_CYCLES = 0
) (
  input  logic           clk,
  input  logic           reset,
  serializer_tx_if.slave in_if,
  output logic           load_out,
  output logic           serial_out,
  output logic           busy,
  output logic           frame_done
);

  localparam int                IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_W - 1);
  localparam bit                HAS_GAP  = (GAP_CYCLES > 0);
  localparam logic [3:0]        GAP_LAST = 4'(HAS_GAP ? GAP_CYCLES - 1 : 0);

  ser_state_t        state, state_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic [IDX_W-1:0]  bit_idx, bit_idx_nxt;
  logic [3:0]        gap_cnt, gap_cnt_nxt;
  logic              frame_end;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;

  assign in_if.in_ready = !fifo_full;
  assign fifo_push      = in_if.in_valid && !fifo_full;

  ser_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (in_if.in_data),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_idx <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      bit_idx <= bit_idx_nxt;
      gap_cnt <= gap_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_idx_nxt = bit_idx;
    gap_cnt_nxt = gap_cnt;
    fifo_pop    = 1'b0;
    load_out    = 1'b0;
    serial_out  = 1'b0;
    busy        = 1'b1;
    frame_done  = 1'b0;
    frame_end   = 1'b0;

    case (state)
      IDLE: begin
        busy = 1'b0;
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shreg_nxt = fifo_head;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        load_out    = 1'b1;
        bit_idx_nxt = '0;
        state_nxt   = SHIFT;
      end
      SHIFT: begin
        serial_out  = shreg[0];
        shreg_nxt   = shreg >> 1;
        bit_idx_nxt = bit_idx + 1'b1;
        if (bit_idx == LAST_IDX) begin
          frame_done  = 1'b1;
          bit_idx_nxt = '0;
          if (HAS_GAP) begin
            gap_cnt_nxt = '0;
            state_nxt   = GAP;
          end else begin
            frame_end = 1'b1;
          end
        end
      end
      GAP: begin
        gap_cnt_nxt = gap_cnt + 1'b1;
        if (gap_cnt == GAP_LAST) frame_end = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase

    // Last shift or last gap cycle chains straight into the next LOAD when a word is waiting.
    if (frame_end) begin
      if (!fifo_empty) begin
        fifo_pop  = 1'b1;
        shreg_nxt = fifo_head;
        state_nxt = LOAD;
      end else begin
        state_nxt = IDLE;
      end
    end
  end

endmodule

// File: tb/tb_serializer_tx.sv
// Directed bench for serializer_tx: timing vectors, back-to-back, backpressure, gap, reset abort, loopback.
module tb_serializer_tx;

  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  serializer_tx_if #(.DATA_W(DW)) if0 ();
  serializer_tx_if #(.DATA_W(DW)) if1 ();

  logic ld0, so0, bz0, fd0;
  logic ld1, so1, bz1, fd1;

  serializer_tx #(.DATA_W(DW), .FIFO_DEPTH(2), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .in_if(if0),
    .load_out(ld0), .serial_out(so0), .busy(bz0), .frame_done(fd0)
  );

  serializer_tx #(.DATA_W(DW), .FIFO_DEPTH(2), .GAP_CYCLES(3)) dut1 (
    .clk(clk), .reset(reset), .in_if(if1),
    .load_out(ld1), .serial_out(so1), .busy(bz1), .frame_done(fd1)
  );

  typedef struct packed {
    logic ld, so, bz, fd, rdy;
    logic ld1, so1, bz1, fd1;
  } smp_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [DW-1:0] first_left;  // expected wire order, leftmost bit transmitted first
  } vec_t;

  int total = 0;
  int bad = 0;
  int words_seen = 0;
  int tc = 0;
  smp_t tr [3000];
  logic [DW-1:0] src_q [$];
  logic [DW-1:0] sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic prime();
    if (src_q.size() > 0) begin
      if0.in_valid = 1'b1;
      if0.in_data  = src_q[0];
    end else begin
      if0.in_valid = 1'b0;
    end
  endtask

  task automatic step();
    logic acc;
    acc = if0.in_valid && if0.in_ready;
    @(posedge clk);
    #1;
    if (acc) sb.push_back(src_q.pop_front());
    prime();
    if (tc < 3000) tr[tc] = '{ld0, so0, bz0, fd0, if0.in_ready, ld1, so1, bz1, fd1};
    tc++;
  endtask

  // Loopback monitor: collects DW bits after each load strobe and checks against the scoreboard.
  initial begin : monitor
    int mcnt;
    bit mact;
    logic [DW-1:0] mword;
    logic [DW-1:0] want;
    mcnt = 0;
    mact = 1'b0;
    mword = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mact = 1'b0;
        mcnt = 0;
      end else if (mact) begin
        mword[mcnt] = so0;
        mcnt++;
        if (mcnt == DW) begin
          mact = 1'b0;
          words_seen++;
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL mon_word: got %0h expected none queued", mword);
          end else begin
            want = sb.pop_front();
            if (mword !== want) begin
              bad++;
              $display("FAIL mon_word: got %0h expected %0h", mword, want);
            end
          end
        end
      end else if (ld0) begin
        mact = 1'b1;
        mcnt = 0;
      end
    end
  end

  initial begin : main
    vec_t vecs [8];
    int n;
    int seen0;
    logic [DW-1:0] e;

    vecs[0] = '{8'hA5, 8'b10100101};
    vecs[1] = '{8'h3C, 8'b00111100};
    vecs[2] = '{8'hC3, 8'b11000011};
    vecs[3] = '{8'h01, 8'b10000000};
    vecs[4] = '{8'h80, 8'b00000001};
    vecs[5] = '{8'hFF, 8'b11111111};
    vecs[6] = '{8'h00, 8'b00000000};
    vecs[7] = '{8'h6D, 8'b10110110};

    if0.in_valid = 1'b0; if0.in_data = '0;
    if1.in_valid = 1'b0; if1.in_data = '0;

    // Reset state, checked before any clock edge and again after a few edges.
    #1 reset = 1'b1;
    #3;
    chk("rst_async_load", {31'd0, ld0}, 0);
    chk("rst_async_ready", {31'd0, if0.in_ready}, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_load", {31'd0, ld0}, 0);
    chk("rst_serial", {31'd0, so0}, 0);
    chk("rst_busy", {31'd0, bz0}, 0);
    chk("rst_done", {31'd0, fd0}, 0);
    chk("rst_ready", {31'd0, if0.in_ready}, 1);
    chk("rst_busy_gap", {31'd0, bz1}, 0);
    reset = 1'b0;

    // Single-word timing vectors from idle.
    for (int v = 0; v < 8; v++) begin
      src_q.push_back(vecs[v].data);
      tc = 0;
      prime();
      repeat (11) step();
      chk($sformatf("v%0d_T_load", v), {31'd0, tr[0].ld}, 0);
      chk($sformatf("v%0d_T_busy", v), {31'd0, tr[0].bz}, 0);
      chk($sformatf("v%0d_load", v), {31'd0, tr[1].ld}, 1);
      chk($sformatf("v%0d_load_ser", v), {31'd0, tr[1].so}, 0);
      chk($sformatf("v%0d_load_busy", v), {31'd0, tr[1].bz}, 1);
      e = vecs[v].first_left;
      for (int k = 0; k < DW; k++) begin
        chk($sformatf("v%0d_bit%0d", v, k), {31'd0, tr[2+k].so}, {31'd0, e[DW-1-k]});
        chk($sformatf("v%0d_fd%0d", v, k), {31'd0, tr[2+k].fd}, (k == DW-1) ? 1 : 0);
        chk($sformatf("v%0d_ld%0d", v, k), {31'd0, tr[2+k].ld}, 0);
      end
      chk($sformatf("v%0d_idle_busy", v), {31'd0, tr[10].bz}, 0);
    end

    // Back-to-back 0x3C then 0xC3, no gap.
    src_q.push_back(8'h3C);
    src_q.push_back(8'hC3);
    tc = 0;
    prime();
    repeat (21) step();
    n = 0;
    for (int k = 0; k < 21; k++) n += tr[k].ld;
    chk("b2b_load_count", n, 2);
    chk("b2b_load1", {31'd0, tr[1].ld}, 1);
    chk("b2b_load2", {31'd0, tr[10].ld}, 1);
    e = 8'b00111100;
    for (int k = 0; k < DW; k++) chk($sformatf("b2b_a_bit%0d", k), {31'd0, tr[2+k].so}, {31'd0, e[DW-1-k]});
    e = 8'b11000011;
    for (int k = 0; k < DW; k++) chk($sformatf("b2b_b_bit%0d", k), {31'd0, tr[11+k].so}, {31'd0, e[DW-1-k]});
    chk("b2b_fd1", {31'd0, tr[9].fd}, 1);
    chk("b2b_fd2", {31'd0, tr[18].fd}, 1);
    chk("b2b_busy_end", {31'd0, tr[19].bz}, 0);

    // Four words held valid into a two-entry FIFO.
    src_q.push_back(8'h11);
    src_q.push_back(8'h22);
    src_q.push_back(8'h33);
    src_q.push_back(8'h44);
    tc = 0;
    prime();
    repeat (40) step();
    chk("hold_rdy1", {31'd0, tr[1].rdy}, 1);
    chk("hold_rdy_full", {31'd0, tr[2].rdy}, 0);
    chk("hold_rdy_still_full", {31'd0, tr[9].rdy}, 0);
    chk("hold_rdy_after_pop", {31'd0, tr[10].rdy}, 1);
    chk("hold_rdy_full2", {31'd0, tr[11].rdy}, 0);
    n = 0;
    for (int k = 0; k < 40; k++) n += tr[k].ld;
    chk("hold_load_count", n, 4);
    chk("hold_load_w1", {31'd0, tr[10].ld}, 1);
    chk("hold_load_w2", {31'd0, tr[19].ld}, 1);
    chk("hold_load_w3", {31'd0, tr[28].ld}, 1);
    chk("hold_busy_end", {31'd0, tr[37].bz}, 0);
    chk("hold_src_drained", src_q.size(), 0);
    chk("hold_sb_drained", sb.size(), 0);

    // Three gap cycles between two frames on the gapped instance.
    tc = 0;
    if1.in_valid = 1'b1;
    if1.in_data  = 8'h12;
    step();
    if1.in_data  = 8'h34;
    step();
    if1.in_valid = 1'b0;
    repeat (25) step();
    chk("gap_load1", {31'd0, tr[1].ld1}, 1);
    e = 8'b01001000;
    for (int k = 0; k < DW; k++) chk($sformatf("gap_a_bit%0d", k), {31'd0, tr[2+k].so1}, {31'd0, e[DW-1-k]});
    chk("gap_fd1", {31'd0, tr[9].fd1}, 1);
    for (int k = 10; k < 13; k++) begin
      chk($sformatf("gap_c%0d_load", k), {31'd0, tr[k].ld1}, 0);
      chk($sformatf("gap_c%0d_ser", k), {31'd0, tr[k].so1}, 0);
      chk($sformatf("gap_c%0d_busy", k), {31'd0, tr[k].bz1}, 1);
    end
    chk("gap_load2", {31'd0, tr[13].ld1}, 1);
    e = 8'b00101100;
    for (int k = 0; k < DW; k++) chk($sformatf("gap_b_bit%0d", k), {31'd0, tr[14+k].so1}, {31'd0, e[DW-1-k]});
    chk("gap_fd2", {31'd0, tr[21].fd1}, 1);
    chk("gap_busy_tail", {31'd0, tr[24].bz1}, 1);
    chk("gap_busy_end", {31'd0, tr[25].bz1}, 0);

    // Reset in the 4th shift cycle with one word still queued.
    seen0 = words_seen;
    src_q.push_back(8'h5A);
    src_q.push_back(8'h96);
    tc = 0;
    prime();
    repeat (6) step();
    chk("rab_busy_before", {31'd0, tr[5].bz}, 1);
    chk("rab_bit3_before", {31'd0, tr[5].so}, 1);
    #1 reset = 1'b1;
    sb.delete();
    #1;
    chk("rab_load", {31'd0, ld0}, 0);
    chk("rab_serial", {31'd0, so0}, 0);
    chk("rab_busy", {31'd0, bz0}, 0);
    chk("rab_done", {31'd0, fd0}, 0);
    chk("rab_ready", {31'd0, if0.in_ready}, 1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tc = 0;
    prime();
    repeat (20) step();
    n = 0;
    for (int k = 0; k < 20; k++) n += tr[k].ld + tr[k].bz;
    chk("rab_quiet_after", n, 0);
    src_q.push_back(8'hE7);
    tc = 0;
    prime();
    repeat (11) step();
    chk("rab_new_load", {31'd0, tr[1].ld}, 1);
    chk("rab_words_seen", words_seen - seen0, 1);

    // Loopback of 256 random words.
    seen0 = words_seen;
    for (int i = 0; i < 256; i++) src_q.push_back(DW'($urandom));
    tc = 0;
    prime();
    n = 0;
    for (int c = 0; c < 4000; c++) begin
      step();
      if (src_q.size() == 0 && sb.size() == 0 && !bz0) begin
        n = 1;
        break;
      end
    end
    chk("loop_finished_in_budget", n, 1);
    chk("loop_words_seen", words_seen - seen0, 256);
    chk("final_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
